// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and load/store
// requests onto one byte-wide RAM port, assembling or splitting 32-bit words.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        mem_ready,
    output logic [31:0] mem_inst,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            2'd0:    size_len = 3'd1;
            2'd1:    size_len = 3'd2;
            default: size_len = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic        last_ls_q, last_ls_d;
    logic        io_q, io_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_inst_q, mem_inst_d;
    logic        ls_ready_q, ls_ready_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        ls_ok_s, if_ok_s, grant_ls_s, grant_if_s, io_stall_s;
    logic [2:0]  cnt_inc_s;
    logic [31:0] addr_next_s;

    // A requester still high during its own completion pulse is not re-served that cycle.
    assign ls_ok_s     = ls_req & ~ls_ready_q;
    assign if_ok_s     = if_req & ~mem_ready_q;
    assign grant_ls_s  = ls_ok_s & (~if_ok_s | ~last_ls_q);
    assign grant_if_s  = if_ok_s & ~grant_ls_s;
    assign io_stall_s  = (state_q == LS_WR) & io_q & io_buffer_full;
    assign cnt_inc_s   = cnt_q + 3'd1;
    assign addr_next_s = base_q + {29'd0, cnt_inc_s};

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q & ~io_stall_s;
    assign mem_ready = mem_ready_q;
    assign mem_inst  = mem_inst_q;
    assign ls_ready  = ls_ready_q;
    assign ls_rdata  = ls_rdata_q;

    // Next-state, arbitration, byte sequencing and output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        last_ls_d   = last_ls_q;
        io_d        = io_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        mem_ready_d = 1'b0;
        mem_inst_d  = mem_inst_q;
        ls_ready_d  = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            IDLE: begin
                mem_a_d    = 32'd0;
                mem_dout_d = 8'd0;
                mem_wr_d   = 1'b0;
                cnt_d      = 3'd0;
                if (flush) begin
                    state_d = IDLE;
                end else if (grant_ls_s) begin
                    base_d    = ls_addr;
                    len_d     = size_len(ls_size);
                    wdata_d   = ls_wdata;
                    io_d      = ls_we & (ls_addr[17:16] == 2'b11);
                    data_d    = 32'd0;
                    mem_a_d   = ls_addr;
                    last_ls_d = 1'b1;
                    if (ls_we) begin
                        state_d    = LS_WR;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = ls_wdata[7:0];
                    end else begin
                        state_d = LS_RD;
                    end
                end else if (grant_if_s) begin
                    base_d    = if_addr;
                    len_d     = 3'd4;
                    io_d      = 1'b0;
                    data_d    = 32'd0;
                    mem_a_d   = if_addr;
                    last_ls_d = 1'b0;
                    state_d   = IF_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            IF_RD, LS_RD: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    mem_a_d = 32'd0;
                    data_d  = 32'd0;
                end else begin
                    // Byte addressed in cycle k lands on mem_din one cycle later.
                    case (cnt_q)
                        3'd1:    data_d[7:0]   = mem_din;
                        3'd2:    data_d[15:8]  = mem_din;
                        3'd3:    data_d[23:16] = mem_din;
                        3'd4:    data_d[31:24] = mem_din;
                        default: data_d        = data_q;
                    endcase
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        mem_a_d = 32'd0;
                        if (state_q == IF_RD) begin
                            mem_ready_d = 1'b1;
                            mem_inst_d  = data_d;
                        end else begin
                            ls_ready_d = 1'b1;
                            ls_rdata_d = data_d;
                        end
                    end else begin
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s < len_q) begin
                            mem_a_d = addr_next_s;
                        end else begin
                            mem_a_d = mem_a_q;
                        end
                    end
                end
            end
            LS_WR: begin
                if (io_stall_s) begin
                    state_d = LS_WR;
                end else if (cnt_inc_s < len_q) begin
                    cnt_d      = cnt_inc_s;
                    mem_a_d    = addr_next_s;
                    mem_dout_d = byte_sel(wdata_q, cnt_inc_s[1:0]);
                end else begin
                    state_d    = IDLE;
                    cnt_d      = 3'd0;
                    mem_a_d    = 32'd0;
                    mem_dout_d = 8'd0;
                    mem_wr_d   = 1'b0;
                    ls_ready_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = 3'd0;
                mem_a_d    = 32'd0;
                mem_dout_d = 8'd0;
                mem_wr_d   = 1'b0;
            end
        endcase
    end

    // State register: async reset, frozen entirely while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            last_ls_q   <= 1'b0;
            io_q        <= 1'b0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            data_q      <= 32'd0;
            mem_a_q     <= 32'd0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_inst_q  <= 32'd0;
            ls_ready_q  <= 1'b0;
            ls_rdata_q  <= 32'd0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            last_ls_q   <= last_ls_d;
            io_q        <= io_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            mem_ready_q <= mem_ready_d;
            mem_inst_q  <= mem_inst_d;
            ls_ready_q  <= ls_ready_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide RAM model and write recorder.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        mem_ready;
    logic [31:0] mem_inst;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_addr = 32'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    logic [7:0]  ram [0:255];
    int          wr_count = 0;
    logic [31:0] last_wr_a;
    logic [7:0]  last_wr_d;
    int          checks = 0;
    int          failures = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .mem_ready(mem_ready), .mem_inst(mem_inst),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: byte for the current address appears next cycle.
    always @(posedge clk) mem_din <= ram[mem_a[7:0]];

    // Record every byte the controller actually writes.
    always @(posedge clk) begin
        if (mem_wr === 1'b1) begin
            wr_count  <= wr_count + 1;
            last_wr_a <= mem_a;
            last_wr_d <= mem_dout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++; if (mem_a !== 32'd0) begin failures++; $display("FAIL reset_mem_a: got %h expected %h", mem_a, 32'd0); end
        checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
        checks++; if (mem_dout !== 8'd0) begin failures++; $display("FAIL reset_mem_dout: got %h expected 00", mem_dout); end
        checks++; if ({mem_ready, ls_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b expected 00", {mem_ready, ls_ready}); end
        checks++; if ({mem_inst, ls_rdata} !== 64'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", {mem_inst, ls_rdata}); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_if_word();
        if_addr = 32'h100; if_req = 1'b1;
        tick();
        if_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (mem_a !== 32'h100 + 32'(k - 1)) begin failures++; $display("FAIL if_addr_%0d: got %h expected %h", k, mem_a, 32'h100 + 32'(k - 1)); end
            tick();
        end
        checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL if_early_ready: got %b expected 0", mem_ready); end
        tick();
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL if_ready: got %b expected 1", mem_ready); end
        checks++; if (mem_inst !== 32'h00100513) begin failures++; $display("FAIL if_inst: got %h expected %h", mem_inst, 32'h00100513); end
        tick();
        checks++; if ({mem_ready, mem_a} !== {1'b0, 32'd0}) begin failures++; $display("FAIL if_after: got %b/%h expected 0/00000000", mem_ready, mem_a); end
        checks++; if (mem_inst !== 32'h00100513) begin failures++; $display("FAIL if_inst_hold: got %h expected %h", mem_inst, 32'h00100513); end
    endtask

    task automatic test_byte_store();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h20; ls_wdata = 32'hAABBCCDD;
        tick();
        ls_req = 1'b0;
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h20, 8'hDD}) begin failures++; $display("FAIL bs_drive: got %b/%h/%h expected 1/00000020/dd", mem_wr, mem_a, mem_dout); end
        tick();
        checks++; if ({ls_ready, mem_wr, mem_dout} !== {1'b1, 1'b0, 8'h00}) begin failures++; $display("FAIL bs_done: got %b/%b/%h expected 1/0/00", ls_ready, mem_wr, mem_dout); end
        tick();
        checks++; if (ls_ready !== 1'b0) begin failures++; $display("FAIL bs_pulse: got %b expected 0", ls_ready); end
        ls_we = 1'b0;
    endtask

    task automatic test_tie();
        rst = 1'b0; #1 rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'h40;
        tick();
        ls_req = 1'b0;
        checks++; if (mem_a !== 32'h40) begin failures++; $display("FAIL tie_ls_first: got %h expected 00000040", mem_a); end
        tick();
        checks++; if (mem_a !== 32'h41) begin failures++; $display("FAIL tie_ls_a1: got %h expected 00000041", mem_a); end
        tick(); tick();
        checks++; if ({ls_ready, ls_rdata} !== {1'b1, 32'h00001234}) begin failures++; $display("FAIL tie_ls_data: got %b/%h expected 1/00001234", ls_ready, ls_rdata); end
        tick();
        checks++; if (mem_a !== 32'h100) begin failures++; $display("FAIL tie_if_next: got %h expected 00000100", mem_a); end
        if_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({mem_ready, mem_inst} !== {1'b1, 32'h00100513}) begin failures++; $display("FAIL tie_if_data: got %b/%h expected 1/00100513", mem_ready, mem_inst); end
        tick();
        if_req = 1'b1; ls_req = 1'b1; ls_size = 2'd0; ls_addr = 32'h41;
        tick();
        if_req = 1'b0; ls_req = 1'b0;
        checks++; if (mem_a !== 32'h41) begin failures++; $display("FAIL tie2_ls: got %h expected 00000041", mem_a); end
        tick(); tick();
        checks++; if ({ls_ready, ls_rdata} !== {1'b1, 32'h00000012}) begin failures++; $display("FAIL tie2_data: got %b/%h expected 1/00000012", ls_ready, ls_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h41;
        tick(); tick(); tick();
        checks++; if (ls_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b expected 1", ls_ready); end
        tick();
        checks++; if ({ls_ready, mem_a} !== {1'b0, 32'd0}) begin failures++; $display("FAIL b2b_ignore: got %b/%h expected 0/00000000", ls_ready, mem_a); end
        tick();
        checks++; if (mem_a !== 32'h41) begin failures++; $display("FAIL b2b_regrant: got %h expected 00000041", mem_a); end
        ls_req = 1'b0;
        tick(); tick();
        checks++; if ({ls_ready, ls_rdata} !== {1'b1, 32'h00000012}) begin failures++; $display("FAIL b2b_data: got %b/%h expected 1/00000012", ls_ready, ls_rdata); end
        tick();
    endtask

    task automatic test_flush_if();
        bit seen = 1'b0;
        if_addr = 32'h100; if_req = 1'b1;
        tick();
        if_req = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (mem_a !== 32'd0) begin failures++; $display("FAIL flush_if_idle: got %h expected 00000000", mem_a); end
        for (int i = 0; i < 6; i++) begin
            if (mem_ready === 1'b1) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_if_ready: got %b expected 0", seen); end
        checks++; if (mem_inst !== 32'h00100513) begin failures++; $display("FAIL flush_if_inst: got %h expected 00100513", mem_inst); end
    endtask

    task automatic test_flush_write();
        logic [31:0] wd = 32'h44332211;
        int          wr0 = wr_count;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h80; ls_wdata = wd;
        tick();
        ls_req = 1'b0; flush = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h80 + 32'(k - 1), wd[8*(k-1) +: 8]}) begin
                failures++; $display("FAIL fw_byte_%0d: got %b/%h/%h expected 1/%h/%h", k, mem_wr, mem_a, mem_dout, 32'h80 + 32'(k - 1), wd[8*(k-1) +: 8]);
            end
            tick();
        end
        checks++; if ({ls_ready, mem_wr} !== 2'b10) begin failures++; $display("FAIL fw_done: got %b expected 10", {ls_ready, mem_wr}); end
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        checks++; if (mem_a !== 32'd0) begin failures++; $display("FAIL fw_no_grant: got %h expected 00000000", mem_a); end
        if_req = 1'b0; flush = 1'b0; ls_we = 1'b0;
        checks++; if (wr_count - wr0 !== 4) begin failures++; $display("FAIL fw_count: got %0d expected 4", wr_count - wr0); end
        checks++; if ({last_wr_a, last_wr_d} !== {32'h83, 8'h44}) begin failures++; $display("FAIL fw_last: got %h/%h expected 00000083/44", last_wr_a, last_wr_d); end
    endtask

    task automatic test_io_write();
        int wr0 = wr_count;
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h0000005A;
        tick();
        ls_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({mem_wr, ls_ready, mem_a} !== {2'b00, 32'h30000}) begin failures++; $display("FAIL io_stall_%0d: got %b/%b/%h expected 0/0/00030000", i, mem_wr, ls_ready, mem_a); end
            tick();
        end
        io_buffer_full = 1'b0;
        #1;
        checks++; if ({mem_wr, mem_dout} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL io_resume: got %b/%h expected 1/5a", mem_wr, mem_dout); end
        tick();
        checks++; if ({ls_ready, mem_wr} !== 2'b10) begin failures++; $display("FAIL io_done: got %b expected 10", {ls_ready, mem_wr}); end
        checks++; if ({wr_count - wr0, last_wr_a} !== {32'd1, 32'h30000}) begin failures++; $display("FAIL io_write: got %0d/%h expected 1/00030000", wr_count - wr0, last_wr_a); end
        ls_we = 1'b0;
        tick();
    endtask

    task automatic test_rdy_freeze();
        int n = 0;
        rdy = 1'b0; if_req = 1'b1; if_addr = 32'h100;
        tick(); tick();
        checks++; if (mem_a !== 32'd0) begin failures++; $display("FAIL rdy_idle_hold: got %h expected 00000000", mem_a); end
        rdy = 1'b1;
        tick();
        if_req = 1'b0; rdy = 1'b0;
        tick(); tick();
        checks++; if (mem_a !== 32'h100) begin failures++; $display("FAIL rdy_busy_hold: got %h expected 00000100", mem_a); end
        rdy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (mem_ready === 1'b1) begin n = i; break; end
        end
        checks++; if (n !== 5) begin failures++; $display("FAIL rdy_latency: got %0d expected 5", n); end
        checks++; if (mem_inst !== 32'h00100513) begin failures++; $display("FAIL rdy_inst: got %h expected 00100513", mem_inst); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        if_addr = 32'h100; if_req = 1'b1;
        tick();
        if_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if ({mem_a, mem_inst, ls_rdata, mem_ready, ls_ready} !== 98'd0) begin failures++; $display("FAIL rstmid_outputs: got %h/%h/%h/%b%b expected all zero", mem_a, mem_inst, ls_rdata, mem_ready, ls_ready); end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_ready === 1'b1 || mem_a !== 32'd0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_quiet: got %b expected 0", seen); end
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h80; ls_wdata = 32'h44332211;
        tick();
        ls_req = 1'b0;
        tick();
        checks++; if (mem_wr !== 1'b1) begin failures++; $display("FAIL rstwr_active: got %b expected 1", mem_wr); end
        rst = 1'b0;
        #1;
        checks++; if ({mem_wr, mem_dout} !== 9'd0) begin failures++; $display("FAIL rstwr_drop: got %b/%h expected 0/00", mem_wr, mem_dout); end
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ls_ready === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstwr_no_ready: got %b expected 0", seen); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h00] = 8'h13; ram[8'h01] = 8'h05; ram[8'h02] = 8'h10; ram[8'h03] = 8'h00;
        ram[8'h40] = 8'h34; ram[8'h41] = 8'h12;
        test_reset();
        test_if_word();
        test_byte_store();
        test_tie();
        test_back_to_back();
        test_flush_if();
        test_flush_write();
        test_io_write();
        test_rdy_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
